// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer_if
//  Description : Switch-conditioning bus. Carries the raw switch levels into
//                the debouncer and the clean levels/edge strobes back out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    // Board side: supplies raw switches, consumes conditioned outputs
    modport master (
        output sw_in,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    // Debouncer side
    modport slave (
        input  sw_in,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer
//  Description : Two-flop synchroniser plus independent per-bit debounce
//                counters for the slide-switch bus. Produces clean levels and
//                registered one-cycle rise/fall/changed strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int WIDTH         = 6,
    parameter int STABLE_CYCLES = 20
) (
    input  logic              clk,
    input  logic              rst,
    switch_debouncer_if.slave sw_bus
);

    localparam int                 c_cnt_w    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_db;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic               r_changed;
    logic [c_cnt_w-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0]   w_flip;

    // Bring the asynchronous switch levels into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_bus.sw_in;
            r_sync2 <= r_sync1;
        end
    end

    // A bit flips when it has disagreed with its debounced value long enough
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_flip[i] = (r_sync2[i] != r_db[i]) && (r_cnt[i] == c_cnt_last);
        end
    end

    // Per-bit disagreement counters, debounced levels and edge strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db      <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // The strobes share the edge on which the new level appears
            r_db      <= r_db ^ w_flip;
            r_rise    <= w_flip & r_sync2;
            r_fall    <= w_flip & ~r_sync2;
            r_changed <= |w_flip;
            for (int i = 0; i < WIDTH; i++) begin
                // Agreement (bounce back) or a completed flip restarts the count
                if ((r_sync2[i] == r_db[i]) || w_flip[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end
            end
        end
    end

    assign sw_bus.sw_db      = r_db;
    assign sw_bus.sw_rise    = r_rise;
    assign sw_bus.sw_fall    = r_fall;
    assign sw_bus.sw_changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debouncer
//  Description : Directed bench for switch_debouncer (WIDTH=6, STABLE_CYCLES=4)
//                with a sample-history reference model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int W = 6;
    localparam int N = 4;

    logic clk;
    logic rst;

    switch_debouncer_if #(.WIDTH(W)) bus ();

    switch_debouncer #(
        .WIDTH        (W),
        .STABLE_CYCLES(N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw_bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_rise2 = 0;
    int n_chg = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: h[0] is the sw_in sample from the previous edge, h[j]
    // the one j edges before that. A bit flips once the last N synchronised
    // samples (h[1..N]) all disagree with its current debounced level.
    logic [W-1:0] h [N+1];
    logic [W-1:0] m_db, m_rise, m_fall, m_flip;
    logic         m_chg;
    logic         m_all;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= N; j++) h[j] = '0;
            m_db = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        end else begin
            m_flip = '0;
            for (int b = 0; b < W; b++) begin
                m_all = 1'b1;
                for (int j = 1; j <= N; j++) begin
                    if (h[j][b] == m_db[b]) m_all = 1'b0;
                end
                m_flip[b] = m_all;
            end
            m_rise = m_flip & ~m_db;
            m_fall = m_flip & m_db;
            m_chg  = |m_flip;
            m_db   = m_db ^ m_flip;
            for (int j = N; j >= 1; j--) h[j] = h[j-1];
            h[0] = bus.sw_in;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_db",   {26'd0, bus.sw_db},   {26'd0, m_db});
            chk("model_rise", {26'd0, bus.sw_rise}, {26'd0, m_rise});
            chk("model_fall", {26'd0, bus.sw_fall}, {26'd0, m_fall});
            chk("model_chg",  {31'd0, bus.sw_changed}, {31'd0, m_chg});
        end
    end

    // Pulse counters
    always @(negedge clk) begin
        if (bus.sw_rise[2]) n_rise2++;
        if (bus.sw_changed) n_chg++;
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_db(input string name, input logic [W-1:0] exp, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk(name, {26'd0, bus.sw_db}, {26'd0, exp});
        end
    endtask

    int base;

    initial begin
        rst = 1'b1;
        bus.sw_in = '0;
        nclk(2);
        // Reset state
        chk("rst_db",   {26'd0, bus.sw_db},   32'h0);
        chk("rst_rise", {26'd0, bus.sw_rise}, 32'h0);
        chk("rst_fall", {26'd0, bus.sw_fall}, 32'h0);
        chk("rst_chg",  {31'd0, bus.sw_changed}, 32'h0);

        // Clean step on bit 0
        rst = 1'b0;
        bus.sw_in = 6'h01;
        hold_db("step_hold", 6'h00, 5);
        @(negedge clk);
        chk("step_db",   {26'd0, bus.sw_db},   32'h01);
        chk("step_rise", {26'd0, bus.sw_rise}, 32'h01);
        chk("step_chg",  {31'd0, bus.sw_changed}, 32'h1);
        @(negedge clk);
        chk("step_rise_end", {26'd0, bus.sw_rise}, 32'h00);
        chk("step_chg_end",  {31'd0, bus.sw_changed}, 32'h0);
        nclk(2);

        // Falling edge on bit 0
        bus.sw_in = 6'h00;
        hold_db("fall_hold", 6'h01, 5);
        @(negedge clk);
        chk("fall_db",   {26'd0, bus.sw_db},   32'h00);
        chk("fall_fall", {26'd0, bus.sw_fall}, 32'h01);
        chk("fall_rise", {26'd0, bus.sw_rise}, 32'h00);
        nclk(3);

        // Bounce rejection on bit 2
        base = n_rise2;
        bus.sw_in = 6'h04; nclk(3);
        bus.sw_in = 6'h00; nclk(3);
        bus.sw_in = 6'h04; nclk(3);
        bus.sw_in = 6'h00; nclk(3);
        chk("bounce_quiet", n_rise2 - base, 32'd0);
        bus.sw_in = 6'h04;
        hold_db("bounce_hold", 6'h00, 5);
        @(negedge clk);
        chk("bounce_db",   {26'd0, bus.sw_db},   32'h04);
        chk("bounce_rise", {26'd0, bus.sw_rise}, 32'h04);
        nclk(3); #1;
        chk("bounce_npulse", n_rise2 - base, 32'd1);
        bus.sw_in = 6'h00;
        nclk(8);

        // Simultaneous flips on bits 4 and 5
        base = n_chg;
        bus.sw_in = 6'h30;
        hold_db("simul_hold", 6'h00, 5);
        @(negedge clk);
        chk("simul_rise", {26'd0, bus.sw_rise}, 32'h30);
        chk("simul_chg",  {31'd0, bus.sw_changed}, 32'h1);
        nclk(3); #1;
        chk("simul_nchg", n_chg - base, 32'd1);
        bus.sw_in = 6'h00;
        nclk(8);

        // Staggered bits: bit 3 first, bit 1 two cycles later
        base = n_chg;
        bus.sw_in = 6'h08;
        nclk(2);
        bus.sw_in = 6'h0A;
        nclk(3);
        @(negedge clk);
        chk("stag_rise3", {26'd0, bus.sw_rise}, 32'h08);
        @(negedge clk);
        chk("stag_gap", {26'd0, bus.sw_rise}, 32'h00);
        @(negedge clk);
        chk("stag_rise1", {26'd0, bus.sw_rise}, 32'h02);
        chk("stag_db",    {26'd0, bus.sw_db},   32'h0A);
        nclk(3); #1;
        chk("stag_nchg", n_chg - base, 32'd2);
        bus.sw_in = 6'h20;
        nclk(10);

        // Asynchronous reset mid-count
        chk("pre_rst_db", {26'd0, bus.sw_db}, 32'h20);
        bus.sw_in = 6'h08;
        nclk(3);
        #2 rst = 1'b1;
        #1;
        chk("arst_db",  {26'd0, bus.sw_db},   32'h00);
        chk("arst_chg", {31'd0, bus.sw_changed}, 32'h0);
        #1 rst = 1'b0;
        base = n_chg;
        hold_db("arst_hold", 6'h00, 5);
        @(negedge clk);
        chk("arst_db_after", {26'd0, bus.sw_db},   32'h08);
        chk("arst_rise",     {26'd0, bus.sw_rise}, 32'h08);
        nclk(3); #1;
        chk("arst_nchg", n_chg - base, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-conditioning stage directly upstream of the SoC general-purpose input port on the board top.
- Synchronises the raw slide-switch bus into the processor clock domain (the 5 kHz divided clock) and debounces each bit independently.
- Presents a clean level bus plus one-cycle edge strobes; the board top feeds the level bus into gpi1 in place of the raw switches.

Parameters:
- WIDTH, 6, number of switch bits conditioned.
- STABLE_CYCLES, 20, consecutive clk cycles a synchronised bit must differ from its debounced value before the debounced value flips (20 at 5 kHz = 4 ms); legal range 1..65535.

Ports:
- clk  input  1  processor-domain clock (board 5 kHz clock).
- rst  input  1  asynchronous, active-high reset.
- sw_in  input  WIDTH  raw, asynchronous switch levels.
- sw_db  output  WIDTH  debounced switch levels.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db[i] goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db[i] goes 1->0.
- sw_changed  output  1  OR-reduction of (sw_rise | sw_fall); one-cycle strobe.

Behaviour:
- Reset: rst is asynchronous and active-high; all flops clear immediately on assertion and remain clear while it is held.
  - Synchroniser flops = 0, per-bit counters = 0.
  - sw_db = 0, sw_rise = 0, sw_fall = 0, sw_changed = 0.
- Synchroniser: two-flop chain per bit (sync1 <= sw_in, sync2 <= sync1); only sync2 is used downstream.
- Per-bit counter:
  - Width CNT_W = clog2(STABLE_CYCLES+1).
  - Independent per bit; no shared state between bits.
- Per-bit rule, evaluated each rising edge:
  - If sync2[i] == sw_db[i]: cnt[i] <= 0; sw_db[i] holds.
  - Else if cnt[i] == STABLE_CYCLES-1: sw_db[i] <= sync2[i]; cnt[i] <= 0; the matching edge pulse asserts on the same edge.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: for a clean step on sw_in[i], sw_db[i] changes on the (STABLE_CYCLES+2)th rising edge, counting the first edge that samples the new level as edge 1.
- Bounce: any cycle in which sync2[i] returns to sw_db[i] clears cnt[i]. A pulse lasting fewer than STABLE_CYCLES synchronised cycles never reaches sw_db.
- Edge pulses:
  - sw_rise[i] and sw_fall[i] are registered and high for exactly the one cycle in which the new sw_db[i] value is first visible.
  - Both are 0 in every other cycle and can never be high together.
- sw_changed is registered and coincident with the edge pulses. It is high for one cycle if any bit flips on that edge; simultaneous flips on several bits produce a single one-cycle strobe.
- Counter saturation is impossible: the counter clears at STABLE_CYCLES-1, so it never wraps.
- Reset mid-count: counts are discarded and sw_db returns to 0. After release, a switch held at 1 re-qualifies with full latency (STABLE_CYCLES+2 edges) and produces a sw_rise pulse.
- No combinational path from sw_in to any output.

Test Plan (STABLE_CYCLES=4, WIDTH=6):
- Clean step: rst released, sw_in 6'h00->6'h01 just before edge 1 -> sw_db=6'h01 after edge 6; sw_rise=6'h01 and sw_changed=1 for that cycle only; sw_db=0 through edge 5.
- Bounce rejection: sw_in[2] toggles 1,0,1,0 at 3-cycle intervals, then holds 1 -> no pulse during bouncing; sw_db[2] rises on the 6th edge after the final 0->1; exactly one sw_rise[2] pulse.
- Falling edge: bit 0 debounced at 1, sw_in[0] -> 0 -> sw_db[0]=0 after 6 edges; sw_fall=6'h01 for one cycle; sw_rise stays 0.
- Simultaneous flips: sw_in 6'h00->6'h30 -> bits 4 and 5 flip on the same edge; sw_rise=6'h30; sw_changed high for exactly one cycle.
- Staggered bits: bit 1 changes 2 cycles after bit 3 -> independent flips 2 cycles apart; sw_changed pulses twice.
- Async reset mid-count: sw_in=6'h08 held, rst pulsed between clock edges after 3 edges -> outputs 0 immediately, without waiting for a clock edge; after release, sw_db=6'h08 exactly 6 edges later with one sw_rise[3] pulse.
